// File: rtl/piso_reg_pkg.sv
// Shared definitions for the parallel-in serial-out shifter.
// SHIFT_ORDER_* keep this block's bit order consistent with the downstream SIPO.
package piso_reg_pkg;

  localparam int unsigned SHIFT_ORDER_LSB = 0;
  localparam int unsigned SHIFT_ORDER_MSB = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_reg.sv
// Parallel-in serial-out shifter with a one-word holding register so that
// back-to-back words stream with no idle gap between them.
module piso_reg
  import piso_reg_pkg::*;
#(
  parameter int unsigned INPUT_BW  = 8,
  parameter int unsigned MSB_FIRST = SHIFT_ORDER_MSB,
  parameter logic        IDLE_BIT  = 1'b0
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [INPUT_BW-1:0] din_bus_i,
  input  logic                din_valid_i,
  output logic                din_ready_o,
  input  logic                pause_i,
  output logic                serial_data_o,
  output logic                wr_en_o,
  output logic                busy_o,
  output logic                word_done_o
);

  localparam int unsigned      CNT_W    = (INPUT_BW > 1) ? $clog2(INPUT_BW) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_BW - 1);

  piso_state_e         r_state;
  piso_state_e         w_state_nxt;
  logic [INPUT_BW-1:0] r_hold;
  logic [INPUT_BW-1:0] r_shift;
  logic [INPUT_BW-1:0] w_shift_nxt;
  logic                r_hold_full;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic                w_accept;
  logic                w_last;
  logic                w_step;
  logic                w_load;
  logic                w_out_bit;

  assign w_accept = din_valid_i & ~r_hold_full;
  assign w_last   = (r_bit_cnt == LAST_CNT);
  assign w_step   = (r_state == ST_SHIFT) & ~pause_i;
  // Load from hold either out of IDLE or as a zero-gap reload after the last bit.
  assign w_load   = r_hold_full & ((r_state == ST_IDLE) | (w_step & w_last));

  if (MSB_FIRST == SHIFT_ORDER_LSB) begin : g_lsb_first
    assign w_out_bit   = r_shift[0];
    assign w_shift_nxt = {1'b0, r_shift[INPUT_BW-1:1]};
  end else begin : g_msb_first
    assign w_out_bit   = r_shift[INPUT_BW-1];
    assign w_shift_nxt = {r_shift[INPUT_BW-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_step && w_last && !r_hold_full) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Holding register, shifter and bit counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_hold      <= din_bus_i;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shift   <= r_hold;
        r_bit_cnt <= '0;
      end else if (w_step && !w_last) begin
        r_shift   <= w_shift_nxt;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs; the serial side idles whenever shifting is frozen or not active.
  always_comb begin
    wr_en_o       = 1'b0;
    serial_data_o = IDLE_BIT;
    word_done_o   = 1'b0;
    din_ready_o   = ~r_hold_full;
    busy_o        = (r_state == ST_SHIFT) | r_hold_full;
    if (w_step) begin
      wr_en_o       = 1'b1;
      serial_data_o = w_out_bit;
      word_done_o   = w_last;
    end
  end

endmodule

// File: tb/tb_piso_reg.sv
// Self-checking bench for piso_reg: an MSB-first instance checked against a bit
// scoreboard plus a SIPO-style word rebuild, and an LSB-first instance.
module tb_piso_reg;

  localparam int unsigned BW = 8;

  typedef struct {
    logic b;
    logic last;
  } sb_bit_t;

  typedef struct {
    logic [7:0] word;
    int         pause_after;
    int         pause_len;
    int         exp_cycles;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] din_bus;
  logic       din_valid;
  logic       din_ready;
  logic       pause;
  logic       ser;
  logic       wr_en;
  logic       busy;
  logic       done;

  logic [7:0] l_din;
  logic       l_valid;
  logic       l_ready;
  logic       l_ser;
  logic       l_wr;
  logic       l_busy;
  logic       l_done;

  int         n_chk;
  int         n_err;
  sb_bit_t    sbq[$];
  logic [7:0] wq[$];
  int         cyc_n;
  int         bits_in_word;
  int         first_cyc;
  int         last_len;
  int         wr_cnt;
  int         done_cnt;
  int         first_wr_cyc;
  int         last_done_cyc;
  logic       acc_seen;
  logic [7:0] sipo;
  logic [7:0] l_bits;
  int         l_cnt;

  piso_reg #(.INPUT_BW(BW), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .din_bus_i(din_bus), .din_valid_i(din_valid),
    .din_ready_o(din_ready), .pause_i(pause), .serial_data_o(ser), .wr_en_o(wr_en),
    .busy_o(busy), .word_done_o(done)
  );

  piso_reg #(.INPUT_BW(BW), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
    .clk_i(clk), .reset_n_i(rst_n), .din_bus_i(l_din), .din_valid_i(l_valid),
    .din_ready_o(l_ready), .pause_i(1'b0), .serial_data_o(l_ser), .wr_en_o(l_wr),
    .busy_o(l_busy), .word_done_o(l_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Samples one cycle's outputs: scoreboard push on handshake, pop on wr_en.
  task automatic monitor();
    sb_bit_t e;
    acc_seen = din_valid & din_ready;
    chk("busy", 32'(busy), 32'(sbq.size() != 0));
    if (acc_seen) begin
      for (int i = BW - 1; i >= 0; i--) begin
        e.b    = din_bus[i];
        e.last = (i == 0);
        sbq.push_back(e);
      end
      wq.push_back(din_bus);
    end
    if (wr_en) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_bit: got wr_en=1 expected wr_en=0 (cycle %0d)", cyc_n);
      end else begin
        e = sbq.pop_front();
        chk("serial_bit", 32'(ser), 32'(e.b));
        chk("word_done", 32'(done), 32'(e.last));
        if (bits_in_word == 0) first_cyc = cyc_n;
        if (wr_cnt == 0) first_wr_cyc = cyc_n;
        wr_cnt++;
        bits_in_word++;
        sipo = {sipo[6:0], ser};
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc_n;
          last_len      = cyc_n - first_cyc + 1;
          bits_in_word  = 0;
          if (wq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL sipo_word: got %0h expected no word", sipo);
          end else begin
            chk("sipo_word", 32'(sipo), 32'(wq.pop_front()));
          end
        end
      end
    end else begin
      chk("idle_bit", 32'(ser), 32'(1'b0));
      chk("idle_done", 32'(done), 32'(1'b0));
    end
    if (l_wr) begin
      if (l_cnt == 7) chk("lsb_done", 32'(l_done), 32'(1'b1));
      if (l_cnt < 8) l_bits[l_cnt] = l_ser;
      l_cnt++;
    end
    cyc_n++;
  endtask

  task automatic cyc();
    #3;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(din_ready), 32'(1'b1));
    chk({tag, "_wr_en"}, 32'(wr_en), 32'(1'b0));
    chk({tag, "_busy"}, 32'(busy), 32'(1'b0));
    chk({tag, "_done"}, 32'(done), 32'(1'b0));
    chk({tag, "_serial"}, 32'(ser), 32'(1'b0));
  endtask

  vec_t       vt[5];
  logic [7:0] b2b[3];

  initial begin
    int guard;
    int d0;
    int idx;
    bit paused;

    n_chk = 0; n_err = 0; cyc_n = 0; bits_in_word = 0; first_cyc = 0;
    last_len = 0; wr_cnt = 0; done_cnt = 0; first_wr_cyc = 0; last_done_cyc = 0;
    acc_seen = 1'b0; sipo = '0; l_bits = '0; l_cnt = 0;
    rst_n = 1'b0; din_bus = '0; din_valid = 1'b0; pause = 1'b0;
    l_din = '0; l_valid = 1'b0;

    vt[0] = '{word: 8'hA5, pause_after: 0, pause_len: 0, exp_cycles: 8};
    vt[1] = '{word: 8'h96, pause_after: 2, pause_len: 3, exp_cycles: 11};
    vt[2] = '{word: 8'h00, pause_after: 0, pause_len: 0, exp_cycles: 8};
    vt[3] = '{word: 8'hFF, pause_after: 7, pause_len: 1, exp_cycles: 9};
    vt[4] = '{word: 8'h5A, pause_after: 1, pause_len: 2, exp_cycles: 10};
    b2b[0] = 8'h3C; b2b[1] = 8'hC3; b2b[2] = 8'hFF;

    // T1: reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_low");
    rst_n = 1'b1;
    #2;
    check_reset_outputs("rst_rel");
    chk("lsb_rst_ready", 32'(l_ready), 32'(1'b1));
    chk("lsb_rst_busy", 32'(l_busy), 32'(1'b0));
    @(posedge clk);
    #1;

    // T2/T5: table of single words, some with pauses
    for (int v = 0; v < 5; v++) begin
      din_bus   = vt[v].word;
      din_valid = 1'b1;
      guard     = 0;
      do begin
        cyc();
        guard++;
      end while (!acc_seen && guard < 20);
      din_valid = 1'b0;
      chk("accepted", 32'(acc_seen), 32'(1'b1));
      paused = 1'b0;
      d0     = done_cnt;
      guard  = 0;
      while (done_cnt == d0 && guard < 40) begin
        if (!paused && vt[v].pause_len > 0 && bits_in_word == vt[v].pause_after) begin
          paused = 1'b1;
          pause  = 1'b1;
          repeat (vt[v].pause_len) cyc();
          pause = 1'b0;
        end else begin
          cyc();
        end
        guard++;
      end
      chk("word_done_count", 32'(done_cnt - d0), 32'd1);
      chk("word_cycles", 32'(last_len), 32'(vt[v].exp_cycles));
      guard = 0;
      while (busy && guard < 5) begin
        cyc();
        guard++;
      end
      chk("idle_ready", 32'(din_ready), 32'(1'b1));
    end

    // T3: back-to-back words with valid held high
    wr_cnt    = 0;
    d0        = done_cnt;
    idx       = 0;
    din_bus   = b2b[0];
    din_valid = 1'b1;
    guard     = 0;
    while (done_cnt - d0 < 3 && guard < 60) begin
      cyc();
      if (acc_seen) begin
        idx++;
        if (idx < 3) din_bus = b2b[idx];
        else din_valid = 1'b0;
      end
      guard++;
    end
    din_valid = 1'b0;
    chk("b2b_wr_cycles", 32'(wr_cnt), 32'd24);
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'd3);
    chk("b2b_span", 32'(last_done_cyc - first_wr_cyc + 1), 32'd24);
    repeat (2) cyc();

    // T4: LSB-first instance, 8'h01 -> 1 then seven 0s
    l_cnt  = 0;
    l_bits = '0;
    chk("lsb_ready", 32'(l_ready), 32'(1'b1));
    l_din   = 8'h01;
    l_valid = 1'b1;
    cyc();
    l_valid = 1'b0;
    repeat (12) cyc();
    chk("lsb_bit_count", 32'(l_cnt), 32'd8);
    chk("lsb_bits", 32'(l_bits), 32'h01);
    chk("lsb_idle_busy", 32'(l_busy), 32'(1'b0));

    // T6: reset mid-word with the hold full
    din_bus   = 8'hC3;
    din_valid = 1'b1;
    guard     = 0;
    do begin
      cyc();
      guard++;
    end while (!acc_seen && guard < 20);
    din_bus = 8'h3C;
    guard   = 0;
    do begin
      cyc();
      guard++;
    end while (!acc_seen && guard < 20);
    din_valid = 1'b0;
    chk("t6_second_accept", 32'(acc_seen), 32'(1'b1));
    guard = 0;
    while (bits_in_word < 4 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("t6_hold_full", 32'(din_ready), 32'(1'b0));
    chk("t6_busy", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    sbq.delete();
    wq.delete();
    bits_in_word = 0;
    sipo         = '0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    wr_cnt = 0;
    repeat (20) cyc();
    chk("t6_no_wr_en", 32'(wr_cnt), 32'd0);
    chk("t6_end_ready", 32'(din_ready), 32'(1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
